prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that drives the external write port of the 32-byte program RAM. It accepts a framed byte stream: length header, data bytes, checksum. It writes the data bytes to RAM addresses 0 upward through the external write strobe, address and data. It holds the CPU/RAM run signal low until a frame with a valid checksum completes, then releases the CPU. It sits between the host/serial front end and the RAM/CPU reset input.

## Interface
- No parameters; RAM depth fixed at 32 bytes (5-bit address).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_req  in  1  single-cycle request to (re)load; aborts any frame, stops the CPU.
- in_valid  in  1  byte-stream source has a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs on an edge where in_valid && in_ready.
- ewr  out  1  external RAM write strobe.
- ead  out  5  external RAM address.
- edat  out  8  external RAM write data.
- cpu_run  out  1  drives the RAM/CPU rst input; 1 = CPU executing, 0 = load mode.
- busy  out  1  frame in progress (DATA or CHECK).
- err  out  1  last frame failed its checksum; sticky.

## Operation
- States: IDLE, DATA, CHECK, RUN.
- in_ready = (state != RUN) && !load_req. This is combinational.
- IDLE, byte accepted:
  - Byte is the header. len = byte[5:0] == 0 ? 32 : byte[5:0].
  - If byte[5:0] > 32, use len = 32.
  - Clear cnt and sum; clear err; go to DATA.
- DATA, byte accepted:
  - Registered write: next cycle ewr=1, ead=cnt, edat=byte, for exactly one cycle.
  - sum = sum + byte (mod 256). cnt = cnt + 1.
  - On the len-th data byte, go to CHECK.
- CHECK, byte accepted:
  - If byte == sum: go to RUN; cpu_run=1 from next cycle.
  - Otherwise: err=1; go to IDLE; cpu_run stays 0.
- RUN: in_ready=0; stream ignored; RAM contents belong to the CPU.
- load_req in any state:
  - Next cycle: state=IDLE, cpu_run=0, err=0, cnt=0, sum=0.
  - A pending ewr pulse from the previous accept still completes.
  - Same-cycle load_req wins over byte acceptance (in_ready forced 0).
- RAM locations at or above len are not written and keep their prior contents.
- ead never exceeds 31.
- cnt is 6 bits internally; ead = cnt[4:0].

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; ewr=0, ead=0, edat=0, cpu_run=0, busy=0, err=0, internal cnt/sum=0.
  - in_ready=1 once rst is high (and load_req=0).
- Throughput: one byte per cycle; in_valid may drop between bytes with no effect on state.
- Write latency: ewr/ead/edat valid in the cycle after the accepting edge. The RAM samples them on the following edge.
- ewr is 0 in every cycle not immediately following a DATA accept. ead/edat hold their last values when ewr=0.
- cpu_run latency: rises on the edge after the checksum accept.
  - The last data write lands no later than that same edge, with cpu_run still sampled as 0, so every write completes in load mode.
- cpu_run falls on the edge after load_req.
- busy=1 exactly while state is DATA or CHECK.
- err changes only on a checksum accept (set), a header accept, load_req, or reset (clear).
- Reset asserted mid-frame: immediate return to reset values. Partial RAM contents are left as written.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 except in_ready=1; no ewr pulses.
- Good frame: stream 0x03, 0x11, 0x22, 0x33, 0x66 back-to-back -> ewr pulses at ead 0/1/2 with edat 0x11/0x22/0x33; cpu_run=1 one cycle after the 0x66 accept; err=0; in_ready=0.
- Bad checksum: stream 0x02, 0xAA, 0x55, 0x00 (sum 0xFF) -> two ewr pulses; err=1; cpu_run=0; state IDLE; in_ready=1. Then send a good frame -> err clears on its header.
- Full depth with gaps: header 0x00, data 0x00..0x1F with in_valid toggling every other cycle, checksum 0xF0 -> 32 writes, last at ead=31; cpu_run=1.
- load_req: in RUN -> cpu_run=0 next cycle, in_ready=1. Mid-DATA after 2 of 4 bytes -> IDLE, busy=0. The next byte is treated as a header; the abandoned frame's remaining bytes are never written.
- Async reset mid-DATA (between clock edges) -> outputs go to reset values immediately, without waiting for a clock edge; cpu_run stays 0.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length/data/checksum frame and writes it
// into the 32-byte program RAM, holding the CPU in load mode until the frame verifies.
module prog_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ewr,
    output logic [4:0] ead,
    output logic [7:0] edat,
    output logic       cpu_run,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, DATA, CHECK, RUN} state_t;

    state_t     state;
    logic [5:0] len;
    logic [5:0] cnt;
    logic [7:0] sum;
    logic [5:0] hdr_len;
    logic       accept;

    always_comb begin
        in_ready = (state != RUN) && !load_req;
        accept   = in_valid && in_ready;
        busy     = (state == DATA) || (state == CHECK);
    end

    // A zero length field means a full 32-byte image; oversize lengths clamp to 32.
    always_comb begin
        hdr_len = in_data[5:0];
        if (in_data[5:0] == 6'd0 || in_data[5:0] > 6'd32)
            hdr_len = 6'd32;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            len     <= 6'd32;
            cnt     <= '0;
            sum     <= '0;
            ewr     <= 1'b0;
            ead     <= '0;
            edat    <= '0;
            cpu_run <= 1'b0;
            err     <= 1'b0;
        end else begin
            ewr <= 1'b0;
            if (load_req) begin
                state   <= IDLE;
                cpu_run <= 1'b0;
                err     <= 1'b0;
                cnt     <= '0;
                sum     <= '0;
            end else if (accept) begin
                case (state)
                    IDLE: begin
                        len   <= hdr_len;
                        cnt   <= '0;
                        sum   <= '0;
                        err   <= 1'b0;
                        state <= DATA;
                    end
                    DATA: begin
                        ewr  <= 1'b1;
                        ead  <= cnt[4:0];
                        edat <= in_data;
                        sum  <= sum + in_data;
                        cnt  <= cnt + 6'd1;
                        if (cnt + 6'd1 == len)
                            state <= CHECK;
                    end
                    CHECK: begin
                        if (in_data == sum) begin
                            state   <= RUN;
                            cpu_run <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: frames are modelled as byte lists, expected
// RAM writes are queued by the driver and checked by an independent ewr monitor.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_req = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       ewr;
    logic [4:0] ead;
    logic [7:0] edat;
    logic       cpu_run;
    logic       busy;
    logic       err;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ewr      (ewr),
        .ead      (ead),
        .edat     (edat),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [12:0] wq[$];
    logic [7:0]  fd[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every ewr pulse must match the oldest expected write.
    initial begin
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && ewr) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ewr: got ead=%0d edat=%0h expected no write", ead, edat);
                end else begin
                    e = wq.pop_front();
                    chk("ead", 32'(ead), 32'(e[12:8]));
                    chk("edat", 32'(edat), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input bit inframe);
        @(negedge clk);
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        chk("in_ready", 32'(in_ready), 32'd1);
        if (inframe) begin
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("err_in_frame", 32'(err), 32'd0);
            chk("cpu_run_in_frame", 32'(cpu_run), 32'd0);
        end
        @(posedge clk);
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic maybe_gap(input int gmode);
        if (gmode == 1) gap();
        else if (gmode == 2 && $urandom_range(0, 3) == 0) gap();
    endtask

    task automatic do_load_req(input bit vld);
        @(negedge clk);
        load_req = 1'b1;
        in_valid = vld;
        in_data  = 8'($urandom);
        #1;
        chk("in_ready_during_load_req", 32'(in_ready), 32'd0);
        @(negedge clk);
        load_req = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("cpu_run_after_load_req", 32'(cpu_run), 32'd0);
        chk("busy_after_load_req", 32'(busy), 32'd0);
        chk("err_after_load_req", 32'(err), 32'd0);
        chk("in_ready_after_load_req", 32'(in_ready), 32'd1);
        chk("writes_pending_after_load_req", 32'(wq.size()), 32'd0);
    endtask

    // cmode: 0 correct checksum, 1 random wrong checksum, 2 explicit value xchk.
    task automatic send_frame(input logic [7:0] hdr, input int gmode, input int cmode,
                              input logic [7:0] xchk, input int abort_at, output bit ran);
        int n;
        logic [7:0] s;
        logic [7:0] cb;
        bit good;
        ran = 1'b0;
        n = int'(hdr[5:0]);
        if (n == 0 || n > 32) n = 32;
        s = 8'h00;
        send_byte(hdr, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (abort_at == i) begin
                do_load_req(1'b1);
                return;
            end
            maybe_gap(gmode);
            send_byte(fd[i], 1'b1);
            wq.push_back({i[4:0], fd[i]});
            s = s + fd[i];
        end
        if (cmode == 0)      cb = s;
        else if (cmode == 1) cb = s + 8'(1 + $urandom_range(0, 254));
        else                 cb = xchk;
        good = (cb == s);
        maybe_gap(gmode);
        send_byte(cb, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("cpu_run_after_frame", 32'(cpu_run), 32'(good));
        chk("err_after_frame", 32'(err), 32'(!good));
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("in_ready_after_frame", 32'(in_ready), 32'(!good));
        chk("writes_pending_after_frame", 32'(wq.size()), 32'd0);
        ran = good;
    endtask

    initial begin
        bit ran;

        // Reset held for three cycles, then released.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({ewr, ead, edat, cpu_run, busy, err}), 32'd0);
        rst = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_outputs_after_release", 32'({ewr, ead, edat, cpu_run, busy, err}), 32'd0);

        // Good frame 03 11 22 33 66.
        fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33;
        send_frame(8'h03, 0, 2, 8'h66, -1, ran);
        chk("good_frame_runs", 32'(ran), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_cpu_run", 32'(cpu_run), 32'd1);
        end
        do_load_req(1'b0);

        // Bad checksum 02 AA 55 00, then a good frame clears err on its header.
        fd[0] = 8'hAA; fd[1] = 8'h55;
        send_frame(8'h02, 0, 2, 8'h00, -1, ran);
        for (int i = 0; i < 5; i++) fd[i] = 8'($urandom);
        send_frame(8'h05, 0, 0, 8'h00, -1, ran);
        do_load_req(1'b0);

        // Full depth with in_valid toggling; checksum is 0xF0.
        for (int i = 0; i < 32; i++) fd[i] = 8'(i);
        send_frame(8'h00, 1, 2, 8'hF0, -1, ran);
        chk("full_depth_runs", 32'(ran), 32'd1);
        do_load_req(1'b0);

        // Abort mid-DATA after 2 of 4 bytes; next byte is a fresh header.
        for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
        send_frame(8'h04, 0, 0, 8'h00, 2, ran);
        fd[0] = 8'h3C; fd[1] = 8'h81;
        send_frame(8'h02, 0, 0, 8'h00, -1, ran);
        do_load_req(1'b0);

        // Asynchronous reset between clock edges mid-DATA.
        send_byte(8'h04, 1'b0);
        send_byte(8'h5A, 1'b1);
        wq.push_back({5'd0, 8'h5A});
        send_byte(8'hC3, 1'b1);
        wq.push_back({5'd1, 8'hC3});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("writes_before_async_reset", 32'(wq.size()), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({ewr, ead, edat, cpu_run, busy, err}), 32'd0);
        repeat (2) @(negedge clk);
        chk("async_reset_cpu_run_held", 32'(cpu_run), 32'd0);
        rst = 1'b1;
        #1;
        chk("after_async_reset_in_ready", 32'(in_ready), 32'd1);
        chk("after_async_reset_busy", 32'(busy), 32'd0);

        // Randomized frames: random header (incl. 0 and >32), gaps, bad checksums, aborts.
        for (int f = 0; f < 25; f++) begin
            int ab;
            int cm;
            for (int i = 0; i < 32; i++) fd[i] = 8'($urandom);
            cm = ($urandom_range(0, 2) == 0) ? 1 : 0;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : -1;
            send_frame(8'($urandom), 2, cm, 8'h00, ab, ran);
            if (ran) do_load_req($urandom_range(0, 1) == 1);
        end

        repeat (4) @(negedge clk);
        chk("writes_pending_at_end", 32'(wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
